// File: rtl/alu_acc_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_acc_sequencer_if
// Command / response handshake bundle for the ALU accumulator sequencer.
//   cmd_valid   : upstream has a command
//   cmd_ready   : sequencer can take a command (IDLE only)
//   cmd_op      : 4-bit command opcode
//   cmd_operand : 16-bit operand B or LOAD value
//   rsp_valid   : sequencer has a response
//   rsp_ready   : downstream takes the response
//   rsp_error   : per-op error code (2'b11 = illegal opcode)
// master = command producer / response consumer, slave = the sequencer.
// ---------------------------------------------------------------------------
interface alu_acc_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_operand;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_error;

  modport master (
    output cmd_valid, cmd_op, cmd_operand, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, rsp_ready,
    output cmd_ready, rsp_valid, rsp_error
  );
endinterface

// File: rtl/alu_acc_sequencer.sv
// ---------------------------------------------------------------------------
// alu_acc_sequencer
// Sequential front-end for a combinational 16-bit ALU. Accepts commands over
// a valid/ready handshake, drives the ALU with acc_lo as A and the command
// operand as B, holds the ALU inputs for SETTLE_CYCLES, captures the 32-bit
// result into the accumulator pair and returns a response over a second
// valid/ready handshake.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   bus        : command/response handshake (slave modport)
//   alu_a/b/op : ALU operand A, operand B, opcode (registered, held)
//   alu_result : ALU 32-bit result
//   alu_error  : ALU error, bit0 add/sub overflow, bit1 divide by zero
//   acc_lo/hi  : accumulator low/high words
//   err_sticky : OR of all captured ALU errors since reset/CLEAR
//   ops_done   : completed responses, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module alu_acc_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_acc_sequencer_if.slave   bus,
  output logic [15:0]          alu_a,
  output logic [15:0]          alu_b,
  output logic [3:0]           alu_op,
  input  logic [31:0]          alu_result,
  input  logic [1:0]           alu_error,
  output logic [15:0]          acc_lo,
  output logic [15:0]          acc_hi,
  output logic [1:0]           err_sticky,
  output logic [CNT_W-1:0]     ops_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_MOD   = 4'd4;
  localparam logic [3:0] OP_LOAD  = 4'd5;
  localparam logic [3:0] OP_CLEAR = 4'd6;

  // Out-of-range settle windows fall back to a single cycle.
  localparam logic [3:0] SETTLE_EFF =
    ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) ? 4'd1 : SETTLE_CYCLES[3:0];

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_cmd_ready,  w_cmd_ready_nxt;
  logic               r_rsp_valid,  w_rsp_valid_nxt;
  logic [1:0]         r_rsp_error,  w_rsp_error_nxt;
  logic [15:0]        r_acc_lo,     w_acc_lo_nxt;
  logic [15:0]        r_acc_hi,     w_acc_hi_nxt;
  logic [1:0]         r_err_sticky, w_err_sticky_nxt;
  logic [CNT_W-1:0]   r_ops_done,   w_ops_done_nxt;
  logic [3:0]         r_cnt,        w_cnt_nxt;
  logic [15:0]        r_alu_a,      w_alu_a_nxt;
  logic [15:0]        r_alu_b,      w_alu_b_nxt;
  logic [3:0]         r_alu_op,     w_alu_op_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-value logic for every register in the block.
  always_comb begin
    w_state_nxt      = r_state;
    w_cmd_ready_nxt  = r_cmd_ready;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_error_nxt  = r_rsp_error;
    w_acc_lo_nxt     = r_acc_lo;
    w_acc_hi_nxt     = r_acc_hi;
    w_err_sticky_nxt = r_err_sticky;
    w_ops_done_nxt   = r_ops_done;
    w_cnt_nxt        = r_cnt;
    w_alu_a_nxt      = r_alu_a;
    w_alu_b_nxt      = r_alu_b;
    w_alu_op_nxt     = r_alu_op;

    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid && r_cmd_ready) begin
          w_cmd_ready_nxt = 1'b0;
          case (bus.cmd_op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: begin
              w_alu_a_nxt  = r_acc_lo;
              w_alu_b_nxt  = bus.cmd_operand;
              w_alu_op_nxt = bus.cmd_op;
              w_cnt_nxt    = SETTLE_EFF;
              w_state_nxt  = ST_EXEC;
            end
            OP_LOAD: begin
              w_acc_lo_nxt    = bus.cmd_operand;
              w_acc_hi_nxt    = 16'd0;
              w_rsp_error_nxt = 2'b00;
              w_rsp_valid_nxt = 1'b1;
              w_state_nxt     = ST_RESP;
            end
            OP_CLEAR: begin
              w_acc_lo_nxt     = 16'd0;
              w_acc_hi_nxt     = 16'd0;
              w_err_sticky_nxt = 2'b00;
              w_rsp_error_nxt  = 2'b00;
              w_rsp_valid_nxt  = 1'b1;
              w_state_nxt      = ST_RESP;
            end
            default: begin
              // Illegal opcode: report it without touching accumulator/sticky.
              w_rsp_error_nxt = 2'b11;
              w_rsp_valid_nxt = 1'b1;
              w_state_nxt     = ST_RESP;
            end
          endcase
        end else begin
          w_cmd_ready_nxt = 1'b1;
        end
      end

      ST_EXEC: begin
        // Counter ends at 0 so it reads as idle after capture.
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_rsp_error_nxt  = alu_error;
          w_err_sticky_nxt = r_err_sticky | alu_error;
          // Divide-by-zero leaves the accumulator alone; overflow is only flagged.
          if (!alu_error[1]) begin
            w_acc_lo_nxt = alu_result[15:0];
            w_acc_hi_nxt = alu_result[31:16];
          end else begin
            w_acc_lo_nxt = r_acc_lo;
            w_acc_hi_nxt = r_acc_hi;
          end
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end

      ST_RESP: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_ops_done_nxt  = r_ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_rsp_valid_nxt = 1'b0;
        w_cmd_ready_nxt = 1'b1;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_error  <= 2'b00;
      r_acc_lo     <= 16'd0;
      r_acc_hi     <= 16'd0;
      r_err_sticky <= 2'b00;
      r_ops_done   <= {CNT_W{1'b0}};
      r_cnt        <= 4'd0;
      r_alu_a      <= 16'd0;
      r_alu_b      <= 16'd0;
      r_alu_op     <= 4'd0;
    end else begin
      r_cmd_ready  <= w_cmd_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_error  <= w_rsp_error_nxt;
      r_acc_lo     <= w_acc_lo_nxt;
      r_acc_hi     <= w_acc_hi_nxt;
      r_err_sticky <= w_err_sticky_nxt;
      r_ops_done   <= w_ops_done_nxt;
      r_cnt        <= w_cnt_nxt;
      r_alu_a      <= w_alu_a_nxt;
      r_alu_b      <= w_alu_b_nxt;
      r_alu_op     <= w_alu_op_nxt;
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_error = r_rsp_error;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_op        = r_alu_op;
  assign acc_lo        = r_acc_lo;
  assign acc_hi        = r_acc_hi;
  assign err_sticky    = r_err_sticky;
  assign ops_done      = r_ops_done;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_acc_sequencer
// Two sequencer instances (settle window 1 and 4), each wired to a
// behavioural ALU. Directed table, hand-written backpressure and mid-EXEC
// reset sequences, then random commands checked against a reference model.
// ---------------------------------------------------------------------------
module tb_alu_acc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int settle [2] = '{1, 4};

  logic        rs [2];
  logic        cv [2];
  logic [3:0]  co [2];
  logic [15:0] cd [2];
  logic        rr [2];

  wire         cr [2];
  wire         rv [2];
  wire [1:0]   re [2];
  wire [15:0]  aa [2];
  wire [15:0]  ab [2];
  wire [3:0]   ao [2];
  wire [31:0]  ar [2];
  wire [1:0]   ae [2];
  wire [15:0]  al [2];
  wire [15:0]  ah [2];
  wire [1:0]   es [2];
  wire [15:0]  od [2];

  // Reference model state per instance.
  logic [15:0] m_lo [2];
  logic [15:0] m_hi [2];
  logic [1:0]  m_st [2];
  logic [15:0] m_ops [2];

  // Behavioural ALU: {error[1:0], result[31:0]}.
  function automatic logic [33:0] alu_f(logic [15:0] a, logic [15:0] b, logic [3:0] op);
    logic [31:0] r;
    logic [1:0]  e;
    logic [15:0] s;
    r = 32'd0;
    e = 2'b00;
    case (op)
      4'd0: begin
        s = a + b;
        r = {15'd0, {1'b0, a} + {1'b0, b}};
        e[0] = (a[15] == b[15]) && (s[15] != a[15]);
      end
      4'd1: begin
        s = a - b;
        r = {16'd0, a} - {16'd0, b};
        e[0] = (a[15] != b[15]) && (s[15] != a[15]);
      end
      4'd2: r = {16'd0, a} * {16'd0, b};
      4'd3: if (b == 16'd0) e[1] = 1'b1; else r = {16'd0, a / b};
      4'd4: if (b == 16'd0) e[1] = 1'b1; else r = {16'd0, a % b};
      default: r = 32'd0;
    endcase
    return {e, r};
  endfunction

  assign {ae[0], ar[0]} = alu_f(aa[0], ab[0], ao[0]);
  assign {ae[1], ar[1]} = alu_f(aa[1], ab[1], ao[1]);

  alu_acc_sequencer_if if0 ();
  alu_acc_sequencer_if if1 ();

  assign if0.cmd_valid = cv[0];
  assign if0.cmd_op = co[0];
  assign if0.cmd_operand = cd[0];
  assign if0.rsp_ready = rr[0];
  assign cr[0] = if0.cmd_ready;
  assign rv[0] = if0.rsp_valid;
  assign re[0] = if0.rsp_error;
  assign if1.cmd_valid = cv[1];
  assign if1.cmd_op = co[1];
  assign if1.cmd_operand = cd[1];
  assign if1.rsp_ready = rr[1];
  assign cr[1] = if1.cmd_ready;
  assign rv[1] = if1.rsp_valid;
  assign re[1] = if1.rsp_error;

  alu_acc_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rs[0]), .bus(if0.slave),
    .alu_a(aa[0]), .alu_b(ab[0]), .alu_op(ao[0]),
    .alu_result(ar[0]), .alu_error(ae[0]),
    .acc_lo(al[0]), .acc_hi(ah[0]), .err_sticky(es[0]), .ops_done(od[0])
  );

  alu_acc_sequencer #(.SETTLE_CYCLES(4), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rs[1]), .bus(if1.slave),
    .alu_a(aa[1]), .alu_b(ab[1]), .alu_op(ao[1]),
    .alu_result(ar[1]), .alu_error(ae[1]),
    .acc_lo(al[1]), .acc_hi(ah[1]), .err_sticky(es[1]), .ops_done(od[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_lo[d] = 16'd0;
    m_hi[d] = 16'd0;
    m_st[d] = 2'b00;
    m_ops[d] = 16'd0;
  endtask

  // Issue one command, wait for its response, stall rdly cycles, then accept.
  task automatic do_cmd(input int d, input logic [3:0] op, input logic [15:0] opnd,
                        input int rdly,
                        output logic [15:0] o_lo, output logic [15:0] o_hi,
                        output logic [1:0] o_err, output logic [1:0] o_st,
                        output logic [15:0] e_lo, output logic [15:0] e_hi,
                        output logic [1:0] e_err, output logic [1:0] e_st);
    logic [33:0] a;
    int w;
    int lat;
    e_err = 2'b00;
    if (op <= 4'd4) begin
      a = alu_f(m_lo[d], opnd, op);
      e_err = a[33:32];
      m_st[d] = m_st[d] | e_err;
      if (!e_err[1]) {m_hi[d], m_lo[d]} = a[31:0];
    end else if (op == 4'd5) begin
      m_lo[d] = opnd;
      m_hi[d] = 16'd0;
    end else if (op == 4'd6) begin
      m_lo[d] = 16'd0;
      m_hi[d] = 16'd0;
      m_st[d] = 2'b00;
    end else begin
      e_err = 2'b11;
    end
    e_lo = m_lo[d];
    e_hi = m_hi[d];
    e_st = m_st[d];

    @(negedge clk);
    w = 0;
    while (!cr[d] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_idle", {31'd0, cr[d]}, 32'd1);
    cv[d] = 1'b1;
    co[d] = op;
    cd[d] = opnd;
    @(posedge clk);
    #1;
    cv[d] = 1'b0;
    lat = 1;
    while (!rv[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, (op <= 4'd4) ? settle[d] + 1 : 1);
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk);
      #1;
    end
    if (rdly > 0) chk("rsp_hold", {31'd0, rv[d]}, 32'd1);
    o_lo = al[d];
    o_hi = ah[d];
    o_err = re[d];
    o_st = es[d];
    @(negedge clk);
    rr[d] = 1'b1;
    @(posedge clk);
    #1;
    rr[d] = 1'b0;
    m_ops[d] = m_ops[d] + 16'd1;
    chk("rsp_drop", {31'd0, rv[d]}, 32'd0);
    chk("ops_done", {16'd0, od[d]}, {16'd0, m_ops[d]});
    chk("cmd_ready_back", {31'd0, cr[d]}, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] opnd;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [1:0]  err;
    logic [1:0]  st;
  } vec_t;

  vec_t tv [17];

  initial begin
    logic [15:0] o_lo, o_hi, e_lo, e_hi;
    logic [1:0]  o_err, o_st, e_err, e_st;
    int w;

    tv[0]  = '{4'd5, 16'd15,     16'h000F, 16'h0000, 2'b00, 2'b00};
    tv[1]  = '{4'd0, 16'd126,    16'h008D, 16'h0000, 2'b00, 2'b00};
    tv[2]  = '{4'd5, 16'd300,    16'h012C, 16'h0000, 2'b00, 2'b00};
    tv[3]  = '{4'd2, 16'd300,    16'h5F90, 16'h0001, 2'b00, 2'b00};
    tv[4]  = '{4'd5, 16'hF3FF,   16'hF3FF, 16'h0000, 2'b00, 2'b00};
    tv[5]  = '{4'd3, 16'd0,      16'hF3FF, 16'h0000, 2'b10, 2'b10};
    tv[6]  = '{4'd6, 16'd0,      16'h0000, 16'h0000, 2'b00, 2'b00};
    tv[7]  = '{4'd5, 16'd7,      16'h0007, 16'h0000, 2'b00, 2'b00};
    tv[8]  = '{4'd9, 16'd55,     16'h0007, 16'h0000, 2'b11, 2'b00};
    tv[9]  = '{4'd5, 16'h7FFF,   16'h7FFF, 16'h0000, 2'b00, 2'b00};
    tv[10] = '{4'd0, 16'd1,      16'h8000, 16'h0000, 2'b01, 2'b01};
    tv[11] = '{4'd1, 16'h9000,   16'hF000, 16'hFFFF, 2'b00, 2'b01};
    tv[12] = '{4'd4, 16'd0,      16'hF000, 16'hFFFF, 2'b10, 2'b11};
    tv[13] = '{4'd5, 16'd100,    16'h0064, 16'h0000, 2'b00, 2'b11};
    tv[14] = '{4'd3, 16'd7,      16'h000E, 16'h0000, 2'b00, 2'b11};
    tv[15] = '{4'd4, 16'd4,      16'h0002, 16'h0000, 2'b00, 2'b11};
    tv[16] = '{4'd6, 16'd0,      16'h0000, 16'h0000, 2'b00, 2'b00};

    for (int d = 0; d < 2; d++) begin
      rs[d] = 1'b0;
      cv[d] = 1'b0;
      co[d] = 4'd0;
      cd[d] = 16'd0;
      rr[d] = 1'b0;
      model_reset(d);
    end
    repeat (2) @(negedge clk);
    rs[0] = 1'b1;
    rs[1] = 1'b1;
    @(posedge clk);
    #1;

    // Reset state.
    for (int d = 0; d < 2; d++) begin
      chk("rst_cmd_ready", {31'd0, cr[d]}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rv[d]}, 32'd0);
      chk("rst_acc", {al[d], ah[d]}, 32'd0);
      chk("rst_misc", {re[d], es[d], od[d], ao[d]}, 32'd0);
      chk("rst_alu_ab", {aa[d], ab[d]}, 32'd0);
    end

    // Directed table on the single-cycle-settle instance.
    for (int i = 0; i < 17; i++) begin
      do_cmd(0, tv[i].op, tv[i].opnd, i % 3, o_lo, o_hi, o_err, o_st, e_lo, e_hi, e_err, e_st);
      chk($sformatf("tbl%0d_lo", i), {16'd0, o_lo}, {16'd0, tv[i].lo});
      chk($sformatf("tbl%0d_hi", i), {16'd0, o_hi}, {16'd0, tv[i].hi});
      chk($sformatf("tbl%0d_err", i), {30'd0, o_err}, {30'd0, tv[i].err});
      chk($sformatf("tbl%0d_sticky", i), {30'd0, o_st}, {30'd0, tv[i].st});
    end

    // Backpressure: ADD stalled 5 cycles with a LOAD queued behind it.
    do_cmd(0, 4'd5, 16'd20, 0, o_lo, o_hi, o_err, o_st, e_lo, e_hi, e_err, e_st);
    @(negedge clk);
    cv[0] = 1'b1;
    co[0] = 4'd0;
    cd[0] = 16'd5;
    @(posedge clk);
    #1;
    co[0] = 4'd5;
    cd[0] = 16'h1234;
    w = 0;
    while (!rv[0] && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'd0, rv[0]}, 32'd1);
      chk("bp_acc", {ah[0], al[0]}, 32'd25);
      chk("bp_cmd_ready", {31'd0, cr[0]}, 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rr[0] = 1'b1;
    @(posedge clk);
    #1;
    rr[0] = 1'b0;
    m_lo[0] = 16'd25;
    m_hi[0] = 16'd0;
    m_ops[0] = m_ops[0] + 16'd1;
    chk("bp_release_valid", {31'd0, rv[0]}, 32'd0);
    chk("bp_release_ready", {31'd0, cr[0]}, 32'd1);
    chk("bp_release_ops", {16'd0, od[0]}, {16'd0, m_ops[0]});
    @(posedge clk);
    #1;
    cv[0] = 1'b0;
    chk("bp_queued_valid", {31'd0, rv[0]}, 32'd1);
    chk("bp_queued_acc", {ah[0], al[0]}, 32'h0000_1234);
    @(negedge clk);
    rr[0] = 1'b1;
    @(posedge clk);
    #1;
    rr[0] = 1'b0;
    m_lo[0] = 16'h1234;
    m_ops[0] = m_ops[0] + 16'd1;
    chk("bp_queued_ops", {16'd0, od[0]}, {16'd0, m_ops[0]});

    // Reset pulse on the 2nd EXEC cycle of a SUB (settle window 4).
    do_cmd(1, 4'd5, 16'd50, 0, o_lo, o_hi, o_err, o_st, e_lo, e_hi, e_err, e_st);
    chk("r4_load", {16'd0, o_lo}, 32'd50);
    @(negedge clk);
    cv[1] = 1'b1;
    co[1] = 4'd1;
    cd[1] = 16'd8;
    @(posedge clk);
    #1;
    cv[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("r4_alu_hold", {aa[1], ab[1]}, {16'd50, 16'd8});
    chk("r4_alu_op", {28'd0, ao[1]}, 32'd1);
    chk("r4_not_done", {31'd0, rv[1]}, 32'd0);
    rs[1] = 1'b0;
    #1;
    chk("r4_async_acc", {al[1], ah[1]}, 32'd0);
    chk("r4_async_misc", {re[1], es[1], od[1], ao[1]}, 32'd0);
    chk("r4_async_alu", {aa[1], ab[1]}, 32'd0);
    chk("r4_async_valid", {31'd0, rv[1]}, 32'd0);
    @(negedge clk);
    rs[1] = 1'b1;
    model_reset(1);
    do_cmd(1, 4'd5, 16'd9, 1, o_lo, o_hi, o_err, o_st, e_lo, e_hi, e_err, e_st);
    chk("r4_after_load", {o_hi, o_lo}, 32'd9);

    // Random commands against the reference model.
    for (int n = 0; n < 190; n++) begin
      int d;
      logic [3:0] op;
      logic [15:0] v;
      d = (n < 150) ? 0 : 1;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      v = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      do_cmd(d, op, v, $urandom_range(0, 3), o_lo, o_hi, o_err, o_st, e_lo, e_hi, e_err, e_st);
      chk("rnd_acc", {o_hi, o_lo}, {e_hi, e_lo});
      chk("rnd_err", {30'd0, o_err}, {30'd0, e_err});
      chk("rnd_sticky", {30'd0, o_st}, {30'd0, e_st});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_acc_sequencer.md
Name: alu_acc_sequencer

Overview:
Sequential front-end for the team's combinational 16-bit ALU (4-bit opcode, 32-bit result, 2-bit error: bit0 add/sub overflow, bit1 div/mod by zero). Accepts commands over a valid/ready handshake and drives the ALU with the accumulator as operand A and the command operand as B. It holds the ALU inputs stable for a settle window, then captures the result into a 32-bit accumulator pair. It returns each response over a second valid/ready handshake.

Parameters:
SETTLE_CYCLES, 1, cycles ALU inputs are held before capture (legal range 1..15)
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block accepts command
cmd_op  in  4  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 LOAD, 6 CLEAR, 7-15 illegal
cmd_operand  in  16  operand B / LOAD value
alu_a  out  16  to ALU inputA
alu_b  out  16  to ALU inputB
alu_op  out  4  to ALU OpCode
alu_result  in  32  from ALU Result
alu_error  in  2  from ALU Error
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_error  out  2  per-op error; 2'b11 = illegal opcode
acc_lo  out  16  accumulator low word
acc_hi  out  16  accumulator high word
err_sticky  out  2  OR of all alu_error captured since reset/CLEAR
ops_done  out  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst low, async): state IDLE. acc_lo, acc_hi, err_sticky, ops_done, rsp_error, settle counter, alu_a, alu_b and alu_op all 0. rsp_valid 0.
- All outputs are registered. cmd_ready is 1 only in IDLE.
- States: IDLE, EXEC, RESP.
- IDLE: on cmd_valid & cmd_ready, latch op and operand.
  - Ops 0-4: drive alu_a=acc_lo, alu_b=operand, alu_op=op. Load the settle counter with SETTLE_CYCLES and go to EXEC.
  - LOAD: acc_lo=operand, acc_hi=0, rsp_error=0. Go to RESP.
  - CLEAR: acc_lo, acc_hi and err_sticky set to 0, rsp_error=0. Go to RESP.
  - Illegal (7-15): accumulator unchanged, rsp_error=2'b11, err_sticky unchanged. Go to RESP.
- EXEC: ALU inputs are held constant. The counter decrements each cycle.
  - On the edge where the counter reaches 1: capture rsp_error=alu_error and err_sticky |= alu_error. Go to RESP.
  - If alu_error[1]=1: accumulator unchanged.
  - Otherwise: acc_lo=alu_result[15:0], acc_hi=alu_result[31:16]. This includes overflow cases; overflow is flagged only.
- RESP: rsp_valid=1. Accumulator and rsp_error are stable.
  - On rsp_valid & rsp_ready: rsp_valid drops, ops_done increments (wraps at all-ones to 0), go to IDLE.
  - rsp_ready held low stalls the block indefinitely with rsp_valid held high.
- Latency, measured from the command-accept edge to rsp_valid high:
  - ALU ops: SETTLE_CYCLES+1 edges.
  - LOAD, CLEAR and illegal: 1 edge.
- Throughput: with rsp_ready tied high, one ALU op per SETTLE_CYCLES+2 cycles.
- The command path does not look at cmd_valid outside IDLE. No command is lost: the upstream holds it while cmd_ready=0.
- alu_a, alu_b and alu_op keep their last values outside EXEC.
- Reset mid-EXEC or mid-RESP: immediate return to the reset values. The in-flight op is discarded and not counted.
- If SETTLE_CYCLES is out of range, the implementation clamps it to 1.

Test Plan:
- Reset then LOAD 15, ADD 126 (SETTLE_CYCLES=1) -> ADD rsp_valid 2 edges after accept; acc_lo=141, acc_hi=0, rsp_error=00, ops_done=2.
- LOAD 300, MUL 300 -> acc_lo=0x5F90, acc_hi=0x0001 (90000), rsp_error=00.
- LOAD 0xF3FF, DIV 0 -> rsp_error=2'b10, acc_lo stays 0xF3FF, err_sticky=2'b10. Then CLEAR -> acc=0, err_sticky=00.
- Illegal op 9 after LOAD 7 -> rsp_error=2'b11, acc_lo=7, err_sticky unchanged, ops_done increments.
- Backpressure: rsp_ready low 5 cycles after an ADD -> rsp_valid held and values stable, cmd_ready=0, a queued cmd_valid is not consumed. Release -> IDLE next cycle, then the queued command is accepted.
- Reset pulse during EXEC of SUB (SETTLE_CYCLES=4, pulse on 2nd EXEC cycle) -> all outputs 0 asynchronously, ops_done=0, next LOAD completes normally.
